// File: rtl/ssd_scan_ctl.sv
// Scan controller for a 4-digit common-anode display with optional leading-zero blanking.
// Outputs decode registered state only, so a load shows one cycle later; there is no backpressure.
module ssd_scan_ctl #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  bcd,
  output logic [3:0]  ssd_ctl,
  output logic [1:0]  digit_idx,
  output logic        frame
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      disp_val;
  logic             lz_en;
  logic             tick;
  logic [3:0]       blank;

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= 2'd0;
      disp_val <= 16'h0000;
      lz_en    <= 1'b0;
      frame    <= 1'b0;
    end else begin
      if (load) begin
        disp_val <= value;
        lz_en    <= blank_lz;
      end
      cnt   <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx + 2'd1;
      // Set on the wrap from the last digit, so it is high during the first slot of the next scan.
      frame <= tick && (idx == 2'd3);
    end
  end

  // A digit is blanked only when it and every digit to its left are zero; digit 0 always shows.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = lz_en && (disp_val[15:12] == 4'd0);
    blank[2] = lz_en && (disp_val[15:8]  == 8'd0);
    blank[1] = lz_en && (disp_val[15:4]  == 12'd0);
  end

  always_comb begin
    bcd = disp_val[3:0];
    case (idx)
      2'd0:    bcd = disp_val[3:0];
      2'd1:    bcd = disp_val[7:4];
      2'd2:    bcd = disp_val[11:8];
      default: bcd = disp_val[15:12];
    endcase
  end

  assign digit_idx = idx;
  assign ssd_ctl   = blank[idx] ? 4'b1111 : ~(4'b0001 << idx);

endmodule

// File: tb/tb_ssd_scan_ctl.sv
// Bench for ssd_scan_ctl at REFRESH_DIV=4: expected {bcd, ssd_ctl, digit_idx, frame} per cycle are queued, then drained.
module tb_ssd_scan_ctl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  bcd;
  logic [3:0]  ssd_ctl;
  logic [1:0]  digit_idx;
  logic        frame;

  logic [10:0] obs;
  logic [10:0] exp_v;
  logic [10:0] sb[$];
  int          n_checks = 0;
  int          n_pass = 0;

  ssd_scan_ctl #(.REFRESH_DIV(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank_lz(blank_lz),
    .bcd(bcd), .ssd_ctl(ssd_ctl), .digit_idx(digit_idx), .frame(frame)
  );

  always #5 clk = ~clk;
  assign obs = {bcd, ssd_ctl, digit_idx, frame};

  task automatic push(input logic [3:0] b, input logic [3:0] s, input logic [1:0] ix,
                      input logic f, input int n);
    repeat (n) sb.push_back({b, s, ix, f});
  endtask

  // Leaves the bench at the negedge right after one reset edge: cnt=0, idx=0.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    load  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    load  = 1'b1;
    value = 16'hABCD;
    @(negedge clk);
    @(negedge clk);
    load = 1'b0;
    push(4'd0, 4'b1110, 2'd0, 1'b0, 4);
    push(4'd0, 4'b1101, 2'd1, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v)
        $display("FAIL reset cyc%0d: got bcd=%h ssd=%b idx=%0d frame=%b, want bcd=%h ssd=%b idx=%0d frame=%b",
                 i, obs[10:7], obs[6:3], obs[2:1], obs[0], exp_v[10:7], exp_v[6:3], exp_v[2:1], exp_v[0]);
      else n_pass++;
      rst_n = 1'b1;
    end
  endtask

  task automatic test_scan();
    int i;
    do_reset();
    value = 16'h1234; blank_lz = 1'b0; load = 1'b1;
    push(4'd4, 4'b1110, 2'd0, 1'b0, 3);
    push(4'd3, 4'b1101, 2'd1, 1'b0, 4);
    push(4'd2, 4'b1011, 2'd2, 1'b0, 4);
    push(4'd1, 4'b0111, 2'd3, 1'b0, 4);
    push(4'd4, 4'b1110, 2'd0, 1'b1, 1);
    push(4'd4, 4'b1110, 2'd0, 1'b0, 3);
    i = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      i++;
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v)
        $display("FAIL scan cyc%0d: got bcd=%h ssd=%b idx=%0d frame=%b, want bcd=%h ssd=%b idx=%0d frame=%b",
                 i, obs[10:7], obs[6:3], obs[2:1], obs[0], exp_v[10:7], exp_v[6:3], exp_v[2:1], exp_v[0]);
      else n_pass++;
      load = 1'b0;
    end
  endtask

  task automatic test_blanking();
    int i;
    for (int c = 0; c < 3; c++) begin
      do_reset();
      blank_lz = 1'b1; load = 1'b1;
      case (c)
        0: begin
          value = 16'h0042;
          push(4'd2, 4'b1110, 2'd0, 1'b0, 3);
          push(4'd4, 4'b1101, 2'd1, 1'b0, 4);
          push(4'd0, 4'b1111, 2'd2, 1'b0, 4);
          push(4'd0, 4'b1111, 2'd3, 1'b0, 4);
        end
        1: begin
          value = 16'h0000;
          push(4'd0, 4'b1110, 2'd0, 1'b0, 3);
          push(4'd0, 4'b1111, 2'd1, 1'b0, 4);
          push(4'd0, 4'b1111, 2'd2, 1'b0, 4);
          push(4'd0, 4'b1111, 2'd3, 1'b0, 4);
        end
        default: begin
          value = 16'h0405;
          push(4'd5, 4'b1110, 2'd0, 1'b0, 3);
          push(4'd0, 4'b1101, 2'd1, 1'b0, 4);
          push(4'd4, 4'b1011, 2'd2, 1'b0, 4);
          push(4'd0, 4'b1111, 2'd3, 1'b0, 4);
        end
      endcase
      i = 0;
      while (sb.size() > 0) begin
        @(negedge clk);
        i++;
        exp_v = sb.pop_front();
        n_checks++;
        if (obs !== exp_v)
          $display("FAIL blank%0d cyc%0d: got bcd=%h ssd=%b idx=%0d frame=%b, want bcd=%h ssd=%b idx=%0d frame=%b",
                   c, i, obs[10:7], obs[6:3], obs[2:1], obs[0], exp_v[10:7], exp_v[6:3], exp_v[2:1], exp_v[0]);
        else n_pass++;
        load = 1'b0;
      end
    end
  endtask

  task automatic test_hold();
    int i;
    do_reset();
    value = 16'h1234; blank_lz = 1'b0; load = 1'b1;
    push(4'd4, 4'b1110, 2'd0, 1'b0, 3);
    push(4'd3, 4'b1101, 2'd1, 1'b0, 4);
    push(4'd2, 4'b1011, 2'd2, 1'b0, 4);
    push(4'd1, 4'b0111, 2'd3, 1'b0, 4);
    push(4'd4, 4'b1110, 2'd0, 1'b1, 1);
    push(4'd4, 4'b1110, 2'd0, 1'b0, 3);
    push(4'd3, 4'b1101, 2'd1, 1'b0, 4);
    i = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      i++;
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v)
        $display("FAIL hold cyc%0d: got bcd=%h ssd=%b idx=%0d frame=%b, want bcd=%h ssd=%b idx=%0d frame=%b",
                 i, obs[10:7], obs[6:3], obs[2:1], obs[0], exp_v[10:7], exp_v[6:3], exp_v[2:1], exp_v[0]);
      else n_pass++;
      load = 1'b0; value = 16'h9999; blank_lz = 1'b1;
    end
  endtask

  task automatic test_mid_reset();
    int i;
    do_reset();
    value = 16'h0034; blank_lz = 1'b1; load = 1'b1;
    push(4'd4, 4'b1110, 2'd0, 1'b0, 3);
    push(4'd3, 4'b1101, 2'd1, 1'b0, 4);
    push(4'd0, 4'b1111, 2'd2, 1'b0, 3);
    push(4'd0, 4'b1110, 2'd0, 1'b0, 4);
    push(4'd0, 4'b1101, 2'd1, 1'b0, 1);
    i = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      i++;
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v)
        $display("FAIL midreset cyc%0d: got bcd=%h ssd=%b idx=%0d frame=%b, want bcd=%h ssd=%b idx=%0d frame=%b",
                 i, obs[10:7], obs[6:3], obs[2:1], obs[0], exp_v[10:7], exp_v[6:3], exp_v[2:1], exp_v[0]);
      else n_pass++;
      load  = 1'b0;
      rst_n = (i != 10);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_load_on_tick();
    int i;
    do_reset();
    value = 16'h1234; blank_lz = 1'b0; load = 1'b1;
    push(4'd4, 4'b1110, 2'd0, 1'b0, 3);
    push(4'd7, 4'b1101, 2'd1, 1'b0, 4);
    push(4'd6, 4'b1011, 2'd2, 1'b0, 1);
    i = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      i++;
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v)
        $display("FAIL loadtick cyc%0d: got bcd=%h ssd=%b idx=%0d frame=%b, want bcd=%h ssd=%b idx=%0d frame=%b",
                 i, obs[10:7], obs[6:3], obs[2:1], obs[0], exp_v[10:7], exp_v[6:3], exp_v[2:1], exp_v[0]);
      else n_pass++;
      if (i == 3) begin
        value = 16'h5678;
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_scan();
    test_blanking();
    test_hold();
    test_mid_reset();
    test_load_on_tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
